// File: rtl/scr1_mem_arbiter.sv
// Two-master arbiter for one SCR1 memif-style memory port.
// M0 is the read-only fetch path and M1 is the data path. One transaction is tracked in flight.

`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif
`ifndef SCR1_IMEM_DWIDTH
`define SCR1_IMEM_DWIDTH 32
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_memif_pkg;
    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

// Handshake: a request transfers on a cycle where s_req_o and s_req_ack_i are both high.
// The response arrives on a later cycle as s_resp_i != NOTRDY and is routed to the owner.
module scr1_mem_arbiter
    import scr1_memif_pkg::*;
#(
    parameter bit SCR1_ARB_RR      = 1'b1,
    parameter bit SCR1_ARB_M1_PRIO = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         m0_req_i,
    output logic                         m0_req_ack_o,
    input  type_scr1_mem_cmd_e           m0_cmd_i,
    input  logic [`SCR1_IMEM_AWIDTH-1:0] m0_addr_i,
    output logic [`SCR1_IMEM_DWIDTH-1:0] m0_rdata_o,
    output type_scr1_mem_resp_e          m0_resp_o,

    input  logic                         m1_req_i,
    output logic                         m1_req_ack_o,
    input  type_scr1_mem_cmd_e           m1_cmd_i,
    input  type_scr1_mem_width_e         m1_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] m1_addr_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] m1_wdata_i,
    output logic [`SCR1_DMEM_DWIDTH-1:0] m1_rdata_o,
    output type_scr1_mem_resp_e          m1_resp_o,

    output logic                         s_req_o,
    input  logic                         s_req_ack_i,
    output type_scr1_mem_cmd_e           s_cmd_o,
    output type_scr1_mem_width_e         s_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0] s_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] s_wdata_o,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] s_rdata_i,
    input  type_scr1_mem_resp_e          s_resp_i
);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_DATA = 1'b1
    } arb_state_e;

    arb_state_e fsm_q, fsm_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic       lock_sel_q, lock_sel_d;

    logic       resp_done;
    logic       window;
    logic       sel;
    logic       sel_req;
    logic       accept;
    logic [`SCR1_DMEM_AWIDTH-1:0] m0_addr_ext;

    always_comb begin
        resp_done = (s_resp_i == SCR1_MEM_RESP_RDY_OK) || (s_resp_i == SCR1_MEM_RESP_RDY_ER);
        window    = (fsm_q == ARB_IDLE) || resp_done;
    end

    // A pending but unaccepted request stays locked so the slave sees a stable address.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel = SCR1_ARB_RR ? ~last_q : SCR1_ARB_M1_PRIO;
        end
        sel_req = sel ? m1_req_i : m0_req_i;
    end

    always_comb begin
        m0_addr_ext = '0;
        m0_addr_ext[`SCR1_IMEM_AWIDTH-1:0] = m0_addr_i;
    end

    always_comb begin
        s_req_o      = window && sel_req;
        accept       = s_req_o && s_req_ack_i;
        m0_req_ack_o = accept && !sel;
        m1_req_ack_o = accept && sel;
        s_width_o    = sel ? m1_width_i : SCR1_MEM_WIDTH_WORD;
        s_cmd_o      = SCR1_MEM_CMD_ERROR;
        s_addr_o     = 'x;
        s_wdata_o    = 'x;
        if (s_req_o) begin
            s_cmd_o   = sel ? m1_cmd_i   : m0_cmd_i;
            s_addr_o  = sel ? m1_addr_i  : m0_addr_ext;
            s_wdata_o = sel ? m1_wdata_i : '0;
        end
    end

    always_comb begin
        m0_resp_o  = SCR1_MEM_RESP_NOTRDY;
        m1_resp_o  = SCR1_MEM_RESP_NOTRDY;
        m0_rdata_o = s_rdata_i[`SCR1_IMEM_DWIDTH-1:0];
        m1_rdata_o = s_rdata_i;
        if (fsm_q == ARB_DATA) begin
            if (owner_q) begin
                m1_resp_o = s_resp_i;
            end else begin
                m0_resp_o = s_resp_i;
            end
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        owner_d    = owner_q;
        last_d     = last_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (accept) begin
            fsm_d   = ARB_DATA;
            owner_d = sel;
            last_d  = sel;
            lock_d  = 1'b0;
        end else begin
            if ((fsm_q == ARB_DATA) && resp_done) begin
                fsm_d = ARB_IDLE;
            end
            if (s_req_o) begin
                lock_d     = 1'b1;
                lock_sel_d = sel;
            end else if (lock_q && !(lock_sel_q ? m1_req_i : m0_req_i)) begin
                lock_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ARB_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    a_resp_only_in_data: assert property (@(posedge clk) disable iff (!rst_n)
        (s_resp_i != SCR1_MEM_RESP_NOTRDY) |-> (fsm_q == ARB_DATA));
    a_m0_read_only: assert property (@(posedge clk) disable iff (!rst_n)
        m0_req_i |-> (m0_cmd_i == SCR1_MEM_CMD_RD));
    a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({m0_req_i, m1_req_i, s_req_ack_i}));
`endif

endmodule

// File: tb/tb_scr1_mem_arbiter.sv
// Directed bench for scr1_mem_arbiter: a per-cycle vector table run against a round-robin
// instance and a fixed-priority (M1 wins) instance, plus hand-written reset sequences.
module tb_scr1_mem_arbiter
    import scr1_memif_pkg::*;
();

    localparam type_scr1_mem_cmd_e  RD = SCR1_MEM_CMD_RD;
    localparam type_scr1_mem_cmd_e  WR = SCR1_MEM_CMD_WR;
    localparam type_scr1_mem_cmd_e  ER = SCR1_MEM_CMD_ERROR;
    localparam type_scr1_mem_resp_e NR = SCR1_MEM_RESP_NOTRDY;
    localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e RE = SCR1_MEM_RESP_RDY_ER;

    typedef struct {
        bit                  rb;
        bit                  fp;
        logic                m0_req;
        logic [31:0]         m0_addr;
        logic                m1_req;
        type_scr1_mem_cmd_e  m1_cmd;
        logic [31:0]         m1_addr;
        logic [31:0]         m1_wdata;
        logic                ack;
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        logic                e_sreq;
        logic [31:0]         e_addr;
        type_scr1_mem_cmd_e  e_cmd;
        logic                e_ack0;
        logic                e_ack1;
        type_scr1_mem_resp_e e_r0;
        type_scr1_mem_resp_e e_r1;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                m0_req = 1'b0;
    type_scr1_mem_cmd_e  m0_cmd = SCR1_MEM_CMD_RD;
    logic [31:0]         m0_addr = '0;
    logic                m1_req = 1'b0;
    type_scr1_mem_cmd_e  m1_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e m1_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]         m1_addr = '0;
    logic [31:0]         m1_wdata = '0;
    logic                s_ack = 1'b0;
    type_scr1_mem_resp_e s_resp = SCR1_MEM_RESP_NOTRDY;
    logic [31:0]         s_rdata = '0;
    bit                  cur_fp = 1'b0;

    // Each instance only sees slave activity while it is the one under test.
    logic                ack_a, ack_b;
    type_scr1_mem_resp_e resp_a, resp_b;
    assign ack_a  = cur_fp ? 1'b0 : s_ack;
    assign ack_b  = cur_fp ? s_ack : 1'b0;
    assign resp_a = cur_fp ? SCR1_MEM_RESP_NOTRDY : s_resp;
    assign resp_b = cur_fp ? s_resp : SCR1_MEM_RESP_NOTRDY;

    logic                 a_m0_ack, a_m1_ack, a_sreq, b_m0_ack, b_m1_ack, b_sreq;
    logic [31:0]          a_m0_rd, a_m1_rd, a_addr, a_wd, b_m0_rd, b_m1_rd, b_addr, b_wd;
    type_scr1_mem_resp_e  a_r0, a_r1, b_r0, b_r1;
    type_scr1_mem_cmd_e   a_cmd, b_cmd;
    type_scr1_mem_width_e a_w, b_w;

    scr1_mem_arbiter #(.SCR1_ARB_RR(1'b1), .SCR1_ARB_M1_PRIO(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_req_ack_o(a_m0_ack), .m0_cmd_i(m0_cmd), .m0_addr_i(m0_addr),
        .m0_rdata_o(a_m0_rd), .m0_resp_o(a_r0),
        .m1_req_i(m1_req), .m1_req_ack_o(a_m1_ack), .m1_cmd_i(m1_cmd), .m1_width_i(m1_width),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_rdata_o(a_m1_rd), .m1_resp_o(a_r1),
        .s_req_o(a_sreq), .s_req_ack_i(ack_a), .s_cmd_o(a_cmd), .s_width_o(a_w),
        .s_addr_o(a_addr), .s_wdata_o(a_wd), .s_rdata_i(s_rdata), .s_resp_i(resp_a)
    );

    scr1_mem_arbiter #(.SCR1_ARB_RR(1'b0), .SCR1_ARB_M1_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_req_ack_o(b_m0_ack), .m0_cmd_i(m0_cmd), .m0_addr_i(m0_addr),
        .m0_rdata_o(b_m0_rd), .m0_resp_o(b_r0),
        .m1_req_i(m1_req), .m1_req_ack_o(b_m1_ack), .m1_cmd_i(m1_cmd), .m1_width_i(m1_width),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_rdata_o(b_m1_rd), .m1_resp_o(b_r1),
        .s_req_o(b_sreq), .s_req_ack_i(ack_b), .s_cmd_o(b_cmd), .s_width_o(b_w),
        .s_addr_o(b_addr), .s_wdata_o(b_wd), .s_rdata_i(s_rdata), .s_resp_i(resp_b)
    );

    logic                o_sreq, o_ack0, o_ack1;
    logic [31:0]         o_addr, o_wd, o_rd0, o_rd1;
    type_scr1_mem_cmd_e  o_cmd;
    type_scr1_mem_resp_e o_r0, o_r1;
    always_comb begin
        o_sreq = cur_fp ? b_sreq   : a_sreq;
        o_ack0 = cur_fp ? b_m0_ack : a_m0_ack;
        o_ack1 = cur_fp ? b_m1_ack : a_m1_ack;
        o_addr = cur_fp ? b_addr   : a_addr;
        o_wd   = cur_fp ? b_wd     : a_wd;
        o_rd0  = cur_fp ? b_m0_rd  : a_m0_rd;
        o_rd1  = cur_fp ? b_m1_rd  : a_m1_rd;
        o_cmd  = cur_fp ? b_cmd    : a_cmd;
        o_r0   = cur_fp ? b_r0     : a_r0;
        o_r1   = cur_fp ? b_r1     : a_r1;
    end

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, exp);
        end
    endtask

    function automatic vec_t v(bit rb, bit fp, logic r0, logic [31:0] a0, logic r1,
            type_scr1_mem_cmd_e c1, logic [31:0] a1, logic [31:0] wd, logic ack,
            type_scr1_mem_resp_e rs, logic [31:0] rd, logic esr, logic [31:0] eaddr,
            type_scr1_mem_cmd_e ecmd, logic ea0, logic ea1,
            type_scr1_mem_resp_e er0, type_scr1_mem_resp_e er1);
        vec_t t;
        t = '{rb, fp, r0, a0, r1, c1, a1, wd, ack, rs, rd, esr, eaddr, ecmd, ea0, ea1, er0, er1};
        return t;
    endfunction

    task automatic drive_idle();
        m0_req = 1'b0; m0_addr = '0; m1_req = 1'b0; m1_cmd = RD;
        m1_addr = '0; m1_wdata = '0; s_ack = 1'b0; s_resp = NR; s_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Single M0 read, response two cycles after accept.
        vecs.push_back(v(0,0, 1,'h100, 0,RD,0,0,        1,NR,0,           1,'h100,RD, 1,0, NR,NR));
        vecs.push_back(v(0,0, 0,'h100, 0,RD,0,0,        0,NR,0,           0,0,ER,     0,0, NR,NR));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,OK,'hDEADBEEF,  0,0,ER,     0,0, OK,NR));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,NR,0,           0,0,ER,     0,0, NR,NR));
        // Round-robin back-to-back, first grant to M0.
        vecs.push_back(v(1,0, 1,'h10,  1,RD,'h20,0,     1,NR,0,           1,'h10,RD,  1,0, NR,NR));
        vecs.push_back(v(0,0, 1,'h10,  1,RD,'h20,0,     1,OK,'h11,        1,'h20,RD,  0,1, OK,NR));
        vecs.push_back(v(0,0, 1,'h10,  1,RD,'h20,0,     1,OK,'h22,        1,'h10,RD,  1,0, NR,OK));
        vecs.push_back(v(0,0, 1,'h10,  1,RD,'h20,0,     1,OK,'h33,        1,'h20,RD,  0,1, OK,NR));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,OK,'h44,        0,0,ER,     0,0, NR,OK));
        // Fixed priority, M1 wins four in a row, then M0.
        vecs.push_back(v(1,1, 1,'h30,  1,RD,'h40,0,     1,NR,0,           1,'h40,RD,  0,1, NR,NR));
        vecs.push_back(v(0,1, 1,'h30,  1,RD,'h40,0,     1,OK,'h1,         1,'h40,RD,  0,1, NR,OK));
        vecs.push_back(v(0,1, 1,'h30,  1,RD,'h40,0,     1,OK,'h2,         1,'h40,RD,  0,1, NR,OK));
        vecs.push_back(v(0,1, 1,'h30,  1,RD,'h40,0,     1,OK,'h3,         1,'h40,RD,  0,1, NR,OK));
        vecs.push_back(v(0,1, 1,'h30,  0,RD,'h40,0,     1,OK,'h4,         1,'h30,RD,  1,0, NR,OK));
        vecs.push_back(v(0,1, 0,0,     0,RD,0,0,        0,OK,'h5,         0,0,ER,     0,0, OK,NR));
        // M1 write held off three cycles stays locked while M0 requests.
        vecs.push_back(v(1,0, 0,'h300, 1,WR,'h200,'h55, 0,NR,0,           1,'h200,WR, 0,0, NR,NR));
        vecs.push_back(v(0,0, 1,'h300, 1,WR,'h200,'h55, 0,NR,0,           1,'h200,WR, 0,0, NR,NR));
        vecs.push_back(v(0,0, 1,'h300, 1,WR,'h200,'h55, 0,NR,0,           1,'h200,WR, 0,0, NR,NR));
        vecs.push_back(v(0,0, 1,'h300, 1,WR,'h200,'h55, 1,NR,0,           1,'h200,WR, 0,1, NR,NR));
        vecs.push_back(v(0,0, 1,'h300, 0,RD,0,0,        1,OK,'h0,         1,'h300,RD, 1,0, NR,OK));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,OK,'h66,        0,0,ER,     0,0, OK,NR));
        // M0 locked, then flushed; M1 takes over.
        vecs.push_back(v(1,0, 1,'h400, 0,RD,'h500,0,    0,NR,0,           1,'h400,RD, 0,0, NR,NR));
        vecs.push_back(v(0,0, 1,'h400, 1,RD,'h500,0,    0,NR,0,           1,'h400,RD, 0,0, NR,NR));
        vecs.push_back(v(0,0, 0,'h400, 1,RD,'h500,0,    0,NR,0,           0,0,ER,     0,0, NR,NR));
        vecs.push_back(v(0,0, 0,0,     1,RD,'h500,0,    0,NR,0,           1,'h500,RD, 0,0, NR,NR));
        vecs.push_back(v(0,0, 0,0,     1,RD,'h500,0,    1,NR,0,           1,'h500,RD, 0,1, NR,NR));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,OK,'h77,        0,0,ER,     0,0, NR,OK));
        // Error response to M1 with a same-cycle grant to M0.
        vecs.push_back(v(1,0, 0,0,     1,RD,'h600,0,    1,NR,0,           1,'h600,RD, 0,1, NR,NR));
        vecs.push_back(v(0,0, 1,'h700, 0,RD,0,0,        1,RE,'hBAD,       1,'h700,RD, 1,0, NR,RE));
        vecs.push_back(v(0,0, 0,0,     0,RD,0,0,        0,NR,0,           0,0,ER,     0,0, NR,NR));

        drive_idle();
        rst_n = 1'b0;
        #22;
        chk("rst_s_req", -1, a_sreq, 1'b0);
        chk("rst_m0_ack", -1, a_m0_ack, 1'b0);
        chk("rst_m1_ack", -1, a_m1_ack, 1'b0);
        chk("rst_m0_resp", -1, a_r0, NR);
        chk("rst_m1_resp", -1, a_r1, NR);
        chk("rst_s_cmd", -1, a_cmd, ER);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rb) do_reset();
            @(negedge clk);
            cur_fp   = vecs[i].fp;
            m0_req   = vecs[i].m0_req;
            m0_addr  = vecs[i].m0_addr;
            m1_req   = vecs[i].m1_req;
            m1_cmd   = vecs[i].m1_cmd;
            m1_addr  = vecs[i].m1_addr;
            m1_wdata = vecs[i].m1_wdata;
            s_ack    = vecs[i].ack;
            s_resp   = vecs[i].resp;
            s_rdata  = vecs[i].rdata;
            #4;
            chk("s_req", i, o_sreq, vecs[i].e_sreq);
            chk("s_cmd", i, o_cmd, vecs[i].e_cmd);
            if (vecs[i].e_sreq) chk("s_addr", i, o_addr, vecs[i].e_addr);
            if (vecs[i].e_sreq && vecs[i].e_cmd == WR) chk("s_wdata", i, o_wd, vecs[i].m1_wdata);
            chk("m0_req_ack", i, o_ack0, vecs[i].e_ack0);
            chk("m1_req_ack", i, o_ack1, vecs[i].e_ack1);
            chk("m0_resp", i, o_r0, vecs[i].e_r0);
            chk("m1_resp", i, o_r1, vecs[i].e_r1);
            if (vecs[i].e_r0 != NR) chk("m0_rdata", i, o_rd0, vecs[i].rdata);
            if (vecs[i].e_r1 != NR) chk("m1_rdata", i, o_rd1, vecs[i].rdata);
        end

        // Still in DATA with M0 as owner: response visible, then async reset drops it at once.
        @(negedge clk);
        cur_fp  = 1'b0;
        drive_idle();
        s_resp  = OK;
        s_rdata = 'h88;
        #2;
        chk("pre_rst_m0_resp", 100, a_r0, OK);
        chk("pre_rst_m0_rdata", 100, a_m0_rd, 'h88);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_req", 101, a_sreq, 1'b0);
        chk("async_rst_m0_resp", 101, a_r0, NR);
        chk("async_rst_m1_resp", 101, a_r1, NR);
        s_resp = NR;
        @(negedge clk);
        rst_n = 1'b1;

        // After reset the round-robin pointer again favours M0.
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 'h900; m1_req = 1'b1; m1_addr = 'hA00; s_ack = 1'b1;
        #4;
        chk("post_rst_m0_ack", 102, a_m0_ack, 1'b1);
        chk("post_rst_addr", 102, a_addr, 'h900);
        @(negedge clk);
        drive_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
